// File: rtl/flit_injector_pkg.sv
// Shared types for the flit injector slice.
//   flit_t            : one ring-mesh flit (destination + payload)
//   injector_state_t  : injector FSM states
//   ST_*              : the same encodings as plain constants for the FSM register
package flit_injector_pkg;

   typedef struct packed {
      logic [7:0]  dest;
      logic [23:0] payload;
   } flit_t;

   localparam int FLIT_W = $bits(flit_t);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      GAP  = 2'd2
   } injector_state_t;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_FIRE = FIRE;
   localparam logic [1:0] ST_GAP  = GAP;

endpackage

// File: rtl/flit_injector_if.sv
// Host/mesh signal bundle of the flit injector.
//   in_flit, in_valid  : host flit offered for buffering
//   in_ready           : injector can accept a flit this cycle
//   ring_busy          : OR of the link enables at the injection node
//   sample_msg         : flit presented to the mesh (zero when not injecting)
//   sample_en          : one-cycle injection strobe
//   pending            : flits currently buffered
// master = host/mesh side, slave = injector side.
interface flit_injector_if
   import flit_injector_pkg::*;
#(
   parameter int DEPTH = 4
);
   localparam int PEND_W = $clog2(DEPTH + 1);

   flit_t             in_flit;
   logic              in_valid;
   logic              in_ready;
   logic              ring_busy;
   flit_t             sample_msg;
   logic              sample_en;
   logic [PEND_W-1:0] pending;

   modport master (
      output in_flit, in_valid, ring_busy,
      input  in_ready, sample_msg, sample_en, pending
   );

   modport slave (
      input  in_flit, in_valid, ring_busy,
      output in_ready, sample_msg, sample_en, pending
   );

endinterface

// File: rtl/flit_injector_fifo.sv
// Synchronous flit FIFO with first-word-fall-through head.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail (caller guarantees !full)
//   pop        : drop the head entry (caller guarantees !empty)
//   head       : current head entry, valid whenever !empty
//   full/empty : derived from the registered occupancy count
//   count      : registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module flit_injector_fifo
   import flit_injector_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  flit_t                        push_data,
   input  logic                         pop,
   output flit_t                        head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   flit_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + CNT_W'(1);
         end else if (pop && !push) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;

   a_no_push_full: assert property (@(posedge clk) disable iff (rst) push |-> !full);
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule

// File: rtl/flit_injector.sv
// Ring-mesh traffic source: buffers host flits and injects them onto the
// mesh through the registered sample_msg/sample_en pair, one flit per
// injection, with GAP_CYCLES idle cycles forced after each injection and
// deferral while the ring carries traffic at the injection point.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : flit_injector_if.slave (host enqueue, ring_busy, mesh outputs,
//              pending count)
// Parameters: DEPTH (buffer entries, power of two >= 2), GAP_CYCLES (0 allows
// back-to-back injection).
//
// state | meaning
// IDLE  | waiting for a buffered flit and a quiet ring
// FIRE  | sample_en high this cycle; may re-fire next edge when GAP_CYCLES == 0
// GAP   | forced idle; last count cycle (gap_cnt == 0) may fire like IDLE
module flit_injector
   import flit_injector_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 8
) (
   input logic             clk,
   input logic             rst,
   flit_injector_if.slave  bus
);

   localparam int PEND_W = $clog2(DEPTH + 1);
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam bit GAP_EN = (GAP_CYCLES > 0);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [1:0]        state;
   logic [GAP_W-1:0]  gap_cnt;
   logic              sample_en_q;
   flit_t             sample_msg_q;

   logic              push;
   logic              pop;
   logic              fire_ok;
   flit_t             head;
   logic              full;
   logic              empty;
   logic [PEND_W-1:0] count;

   // in_ready is registered-count based only; a pop on the same edge does
   // not open a slot for that cycle's push.
   assign push = bus.in_valid && !full;

   flit_injector_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.in_flit),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // The gap counter holds GAP_CYCLES-1 on entry to GAP and the final GAP
   // cycle is allowed to fire, which spaces strobes exactly GAP_CYCLES+1
   // cycles apart while the ring is quiet.
   always_comb begin
      fire_ok = 1'b0;
      case (state)
         ST_IDLE: fire_ok = 1'b1;
         ST_FIRE: fire_ok = !GAP_EN;
         ST_GAP:  fire_ok = (gap_cnt == '0);
         default: fire_ok = 1'b0;
      endcase
   end

   assign pop = fire_ok && !empty && !bus.ring_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         gap_cnt      <= '0;
         sample_en_q  <= 1'b0;
         sample_msg_q <= '0;
      end else begin
         sample_en_q  <= pop;
         sample_msg_q <= pop ? head : '0;
         if (pop) begin
            state <= ST_FIRE;
         end else begin
            case (state)
               ST_FIRE: begin
                  if (GAP_EN) begin
                     state   <= ST_GAP;
                     gap_cnt <= GAP_LOAD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_GAP: begin
                  if (gap_cnt == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     gap_cnt <= gap_cnt - GAP_W'(1);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.in_ready   = !full;
   assign bus.sample_en  = sample_en_q;
   assign bus.sample_msg = sample_msg_q;
   assign bus.pending    = count;

   a_single_strobe: assert property (@(posedge clk) disable iff (rst)
      (GAP_EN && sample_en_q) |=> !sample_en_q);

endmodule
